// File: rtl/ela_pkg.sv
// Shared constants, state encodings and address helper for the ELA sequencer.
package ela_pkg;

    localparam int unsigned W_DEF    = 32;
    localparam int unsigned ROWS_DEF = 16;
    localparam int unsigned AW_DEF   = 10;
    localparam int unsigned DW_DEF   = 8;

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t LOAD   = 3'd1;
    localparam state_t RDUP   = 3'd2;
    localparam state_t INTERP = 3'd3;
    localparam state_t DONE   = 3'd4;

    // Linear address of pixel col in output row out_row, w pixels per row.
    function automatic int unsigned rc_addr(input int unsigned out_row,
                                            input int unsigned col,
                                            input int unsigned w);
        return out_row * w + col;
    endfunction

endpackage

// File: rtl/ela_seq_ctrl_if.sv
// Pixel source, result memory and datapath signals of the ELA sequencer.
interface ela_seq_ctrl_if #(
    parameter int unsigned W  = 32,
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 8
);
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    logic          req;
    logic [DW-1:0] in_data;
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_wr;
    logic [DW-1:0] data_rd;
    logic          dp_lo_we;
    logic [DW-1:0] dp_lo_data;
    logic          dp_up_we;
    logic [DW-1:0] dp_up_data;
    logic [CW-1:0] dp_col;
    logic [DW-1:0] dp_result;

    modport master (
        output req, wen, addr, data_wr, dp_lo_we, dp_lo_data, dp_up_we, dp_up_data, dp_col,
        input  in_data, data_rd, dp_result
    );

    modport slave (
        input  req, wen, addr, data_wr, dp_lo_we, dp_lo_data, dp_up_we, dp_up_data, dp_col,
        output in_data, data_rd, dp_result
    );

endinterface

// File: rtl/ela_addr_gen.sv
// Row/column counters, wrap detection and per-state memory address for the ELA sequencer.
module ela_addr_gen
    import ela_pkg::*;
#(
    parameter int unsigned W    = W_DEF,
    parameter int unsigned ROWS = ROWS_DEF,
    parameter int unsigned AW   = AW_DEF,
    localparam int unsigned CW  = (W > 1) ? $clog2(W) : 1,
    localparam int unsigned RW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  state_t        state,
    input  logic          row_inc,
    output logic [CW-1:0] col,
    output logic          col_last,
    output logic          row_first,
    output logic          row_last,
    output logic [AW-1:0] addr
);

    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic          active;
    int unsigned   row_i;
    int unsigned   col_i;

    assign active    = (state == LOAD) || (state == RDUP) || (state == INTERP);
    assign col_last  = (col_q == CW'(W - 1));
    assign row_first = (row_q == '0);
    assign row_last  = (row_q == RW'(ROWS - 1));
    assign col       = col_q;
    assign row_i     = 32'(row_q);
    assign col_i     = 32'(col_q);

    // Column counter: runs in active states, wraps at W-1 which is also every state exit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q <= '0;
        end else if (active && !col_last) begin
            col_q <= col_q + 1'b1;
        end else begin
            col_q <= '0;
        end
    end

    // Row counter: advanced by the sequencer after a row's final write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q <= '0;
        end else if (row_inc) begin
            row_q <= row_q + 1'b1;
        end
    end

    // Address select: even row for input, previous even row for readback, odd row between.
    always_comb begin
        addr = '0;
        case (state)
            LOAD:    addr = AW'(rc_addr(2 * row_i, col_i, W));
            RDUP:    addr = AW'(rc_addr(2 * row_i - 2, col_i, W));
            INTERP:  addr = AW'(rc_addr(2 * row_i - 1, col_i, W));
            default: addr = '0;
        endcase
    end

endmodule

// File: rtl/ela_seq_ctrl.sv
// ELA interpolation sequencer: loads input rows, reads back the previous row into the
// datapath and writes the interpolated row between them.
// Optional: define ELA_CYCLE_CNT_EN to add the cyc_cnt active-cycle counter output.
module ela_seq_ctrl
    import ela_pkg::*;
#(
    parameter int unsigned W    = W_DEF,
    parameter int unsigned ROWS = ROWS_DEF,
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned DW   = DW_DEF
) (
    input  logic clk,
    input  logic rst,
    ela_seq_ctrl_if.master bus,
    output logic done
`ifdef ELA_CYCLE_CNT_EN
    ,
    output logic [15:0] cyc_cnt
`endif
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    state_t        state_q;
    state_t        state_d;
    logic          row_inc;
    logic [CW-1:0] col;
    logic          col_last;
    logic          row_first;
    logic          row_last;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_mux;

    ela_addr_gen #(
        .W    (W),
        .ROWS (ROWS),
        .AW   (AW)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .state     (state_q),
        .row_inc   (row_inc),
        .col       (col),
        .col_last  (col_last),
        .row_first (row_first),
        .row_last  (row_last),
        .addr      (addr)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and row advance; every active state lasts exactly W cycles.
    always_comb begin
        state_d = state_q;
        row_inc = 1'b0;
        case (state_q)
            IDLE: state_d = LOAD;
            LOAD: begin
                if (col_last) begin
                    if (row_first) begin
                        row_inc = 1'b1;
                        state_d = LOAD;
                    end else begin
                        state_d = RDUP;
                    end
                end
            end
            RDUP: begin
                if (col_last) begin
                    state_d = INTERP;
                end
            end
            INTERP: begin
                if (col_last) begin
                    if (row_last) begin
                        state_d = DONE;
                    end else begin
                        row_inc = 1'b1;
                        state_d = LOAD;
                    end
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Moore output decode from registered state and counters.
    always_comb begin
        bus.req      = (state_q == LOAD) && (col == '0);
        bus.wen      = (state_q == LOAD) || (state_q == INTERP);
        bus.dp_lo_we = (state_q == LOAD);
        bus.dp_up_we = (state_q == RDUP);
        bus.dp_col   = col;
        bus.addr     = addr;
        done         = (state_q == DONE);
    end

    assign wr_mux         = (state_q == INTERP) ? bus.dp_result : bus.in_data;
    assign bus.data_wr    = wr_mux;
    assign bus.dp_lo_data = bus.in_data;
    assign bus.dp_up_data = bus.data_rd;

`ifdef ELA_CYCLE_CNT_EN
    logic [15:0] cyc_cnt_q;

    // Active-cycle counter; holds its value once the frame is done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt_q <= '0;
        end else if ((state_q == LOAD) || (state_q == RDUP) || (state_q == INTERP)) begin
            cyc_cnt_q <= cyc_cnt_q + 16'd1;
        end
    end

    assign cyc_cnt = cyc_cnt_q;
`endif

endmodule

// File: tb/tb_ela_seq_ctrl.sv
// Directed bench for ela_seq_ctrl: pixel source, result memory and averaging datapath models.
module tb_ela_seq_ctrl;

    localparam int W    = 32;
    localparam int ROWS = 16;
    localparam int AW   = 10;
    localparam int DW   = 8;
    localparam int CW   = $clog2(W);

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic done;
`ifdef ELA_CYCLE_CNT_EN
    logic [15:0] cyc_cnt;
`endif

    always #5 clk = ~clk;

    ela_seq_ctrl_if #(.W(W), .AW(AW), .DW(DW)) bus ();

    ela_seq_ctrl #(
        .W    (W),
        .ROWS (ROWS),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .done (done)
`ifdef ELA_CYCLE_CNT_EN
        ,
        .cyc_cnt (cyc_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    logic [7:0] seed = 8'h00;

    function automatic logic [7:0] pix(input logic [7:0] s, input int r, input int c);
        return 8'((r * W + c + int'(s)) & 255);
    endfunction

    function automatic logic [7:0] gold(input logic [7:0] s, input int out_row, input int c);
        int r;
        if (out_row % 2 == 0) return pix(s, out_row / 2, c);
        r = (out_row + 1) / 2;
        return 8'((int'(pix(s, r - 1, c)) + int'(pix(s, r, c))) >> 1);
    endfunction

    // Result memory: asynchronous read, write on rising edge.
    logic [7:0] mem [0:1023];
    always @(posedge clk) begin
        if (bus.wen) mem[bus.addr] <= bus.data_wr;
    end
    assign bus.data_rd = mem[bus.addr];

    // Averaging datapath model.
    logic [7:0] lo_line [0:W-1];
    logic [7:0] up_line [0:W-1];
    always @(posedge clk) begin
        if (bus.dp_lo_we) lo_line[bus.dp_col] <= bus.dp_lo_data;
        if (bus.dp_up_we) up_line[bus.dp_col] <= bus.dp_up_data;
    end
    assign bus.dp_result = 8'((9'(lo_line[bus.dp_col]) + 9'(up_line[bus.dp_col])) >> 1);

    // Pixel source: pixel 0 alongside req, then one pixel per cycle.
    int src_row;
    int src_col;
    int req_cnt;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_row <= 0;
            src_col <= 0;
            req_cnt <= 0;
        end else if (bus.req) begin
            src_row <= req_cnt;
            src_col <= 1;
            req_cnt <= req_cnt + 1;
        end else if (src_col != 0 && src_col < W - 1) begin
            src_col <= src_col + 1;
        end
    end
    assign bus.in_data = bus.req ? pix(seed, req_cnt, 0) : pix(seed, src_row, src_col);

    logic [31:0] obs_vec;
    assign obs_vec = 32'({bus.req, bus.wen, bus.dp_lo_we, bus.dp_up_we, done, bus.addr,
                          bus.dp_col});

    function automatic logic [31:0] evec(input bit rq, input bit we, input bit lo, input bit up,
                                         input bit dn, input int a, input int c);
        return 32'({rq, we, lo, up, dn, AW'(a), CW'(c)});
    endfunction

    // Walks the expected frame cycle by cycle; optionally stops mid-RDUP of abort_row.
    task automatic run_frame(input int abort_row, output bit aborted);
        int req_seen;
        req_seen = 0;
        aborted  = 1'b0;
        #1 check("idle", obs_vec, evec(0, 0, 0, 0, 0, 0, 0));
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < W; c++) begin
                @(negedge clk);
                req_seen += int'(bus.req);
                check($sformatf("load_r%0d_c%0d", r, c), obs_vec,
                      evec(c == 0, 1, 1, 0, 0, 2 * r * W + c, c));
                check($sformatf("load_wr_r%0d_c%0d", r, c), 32'(bus.data_wr), 32'(pix(seed, r, c)));
            end
            if (r > 0) begin
                for (int c = 0; c < W; c++) begin
                    @(negedge clk);
                    check($sformatf("rdup_r%0d_c%0d", r, c), obs_vec,
                          evec(0, 0, 0, 1, 0, (2 * r - 2) * W + c, c));
                    if (r == abort_row && c == 10) begin
                        aborted = 1'b1;
                        return;
                    end
                end
                for (int c = 0; c < W; c++) begin
                    @(negedge clk);
                    check($sformatf("interp_r%0d_c%0d", r, c), obs_vec,
                          evec(0, 1, 0, 0, 0, (2 * r - 1) * W + c, c));
                    check($sformatf("interp_wr_r%0d_c%0d", r, c), 32'(bus.data_wr),
                          32'(gold(seed, 2 * r - 1, c)));
                end
            end
        end
        @(negedge clk);
        check("done_rise", obs_vec, evec(0, 0, 0, 0, 1, 0, 0));
        check("req_pulses", 32'(req_seen), 32'(ROWS));
    endtask

    task automatic check_mem(input string tag);
        int even_bad;
        int odd_bad;
        int edge_bad;
        int mid_bad;
        even_bad = 0;
        odd_bad  = 0;
        edge_bad = 0;
        mid_bad  = 0;
        for (int orow = 0; orow < 2 * ROWS - 1; orow++) begin
            for (int c = 0; c < W; c++) begin
                if (mem[orow * W + c] !== gold(seed, orow, c)) begin
                    if (orow % 2 == 0) even_bad++;
                    else odd_bad++;
                    if (c == 0 || c == W - 1) edge_bad++;
                    else mid_bad++;
                end
            end
        end
        check({tag, "_even_rows"}, 32'(even_bad), 32'd0);
        check({tag, "_odd_rows"}, 32'(odd_bad), 32'd0);
        check({tag, "_edge_cols"}, 32'(edge_bad), 32'd0);
        check({tag, "_mid_cols"}, 32'(mid_bad), 32'd0);
    endtask

    initial begin
        bit ab;
        rst  = 1'b0;
        seed = 8'h00;
        repeat (2) @(negedge clk);
        #1 check("reset", obs_vec, evec(0, 0, 0, 0, 0, 0, 0));

        // Frame 1: ramp image.
        @(negedge clk);
        rst = 1'b1;
        run_frame(-1, ab);
`ifdef ELA_CYCLE_CNT_EN
        check("cyc_cnt_done", 32'(cyc_cnt), 32'd1472);
`endif
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            check("done_hold", obs_vec, evec(0, 0, 0, 0, 1, 0, 0));
        end
`ifdef ELA_CYCLE_CNT_EN
        check("cyc_cnt_hold", 32'(cyc_cnt), 32'd1472);
`endif
        check_mem("f1");

        // Frame 2: interrupted by reset in the middle of row 5 readback.
        rst  = 1'b0;
        seed = 8'h55;
        @(negedge clk);
        rst = 1'b1;
        run_frame(5, ab);
        check("abort_reached", 32'(ab), 32'd1);
        #2 rst = 1'b0;
        #1 check("midreset", obs_vec, evec(0, 0, 0, 0, 0, 0, 0));
`ifdef ELA_CYCLE_CNT_EN
        check("cyc_cnt_reset", 32'(cyc_cnt), 32'd0);
`endif

        // Frame 3: full restart with a different image.
        seed = 8'hA3;
        @(negedge clk);
        rst = 1'b1;
        run_frame(-1, ab);
        repeat (3) begin
            @(negedge clk);
            check("done_hold2", obs_vec, evec(0, 0, 0, 0, 1, 0, 0));
        end
        check_mem("f3");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
